mcd212_ram_arbiter: RTL and testbench



---
 rtl/mcd212_pkg.sv | 25 ++
 rtl/mcd212_ram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mcd212_ram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcd212_pkg.sv
// Shared types and helpers for the MCD212 system RAM path.
// The CPU-to-RAM bank swizzle lives here so every CPU-side RAM user agrees on it.
package mcd212_pkg;

   typedef enum logic [1:0] {
      REQ_CH1 = 2'd0,
      REQ_CH2 = 2'd1,
      REQ_CPU = 2'd2
   } ram_requester_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

   typedef logic [18:0] ram_word_addr_t;

   // A18 selects the bank, so it becomes the top RAM index bit; A21 follows it.
   function automatic ram_word_addr_t cpu_to_ram_addr(input logic [22:1] cpu_addr);
      return {cpu_addr[18], cpu_addr[21], cpu_addr[17:1]};
   endfunction

endpackage

// File: rtl/mcd212_ram_arbiter.sv
// Arbitrates the shared MCD212 DRAM port between the CPU and two video fetch channels.
// One access in flight; fixed priority ch1 > ch2 > cpu with a CPU starvation slot.
module mcd212_ram_arbiter
   import mcd212_pkg::*;
#(
   parameter int RAM_LATENCY    = 1,
   parameter int CPU_SLOT_EVERY = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_req,
   input  logic [22:1] cpu_addr,
   input  logic        cpu_write,
   input  logic        cpu_uds,
   input  logic        cpu_lds,
   input  logic [15:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   input  logic        ch1_req,
   input  logic [18:0] ch1_addr,
   input  logic        ch2_req,
   input  logic [18:0] ch2_addr,
   output logic        ch1_valid,
   output logic        ch2_valid,
   output logic [15:0] ch_rdata,
   output logic        ram_en,
   output logic        ram_we,
   output logic [1:0]  ram_be,
   output logic [18:0] ram_addr,
   output logic [15:0] ram_wdata,
   input  logic [15:0] ram_rdata
);

   localparam logic [2:0] LAT_LOAD   = 3'(RAM_LATENCY);
   localparam logic [3:0] SLOT_LIMIT = 4'(CPU_SLOT_EVERY);

   arb_state_e     state_q, state_d;
   ram_requester_e winner_q, winner_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [3:0]     vid_run_q, vid_run_d;
   logic           mask_q, mask_d;
   logic           nop_q, nop_d;
   logic           ram_en_q, ram_en_d;
   logic           ram_we_q, ram_we_d;
   logic [1:0]     ram_be_q, ram_be_d;
   ram_word_addr_t ram_addr_q, ram_addr_d;
   logic [15:0]    ram_wdata_q, ram_wdata_d;
   logic           cpu_ack_q, cpu_ack_d;
   logic           ch1_valid_q, ch1_valid_d;
   logic           ch2_valid_q, ch2_valid_d;
   logic [15:0]    cpu_rdata_q, cpu_rdata_d;
   logic [15:0]    ch_rdata_q, ch_rdata_d;

   logic ch1_live, ch2_live, cpu_live, cpu_slot;

   // The requester served last is invisible for the one IDLE cycle after its pulse.
   assign ch1_live = ch1_req && !(mask_q && winner_q == REQ_CH1);
   assign ch2_live = ch2_req && !(mask_q && winner_q == REQ_CH2);
   assign cpu_live = cpu_req && !(mask_q && winner_q == REQ_CPU);
   assign cpu_slot = cpu_live && (vid_run_q == SLOT_LIMIT);

   always_comb begin
      state_d     = state_q;
      winner_d    = winner_q;
      cnt_d       = cnt_q;
      vid_run_d   = vid_run_q;
      mask_d      = 1'b0;
      nop_d       = nop_q;
      ram_en_d    = 1'b0;
      ram_we_d    = ram_we_q;
      ram_be_d    = ram_be_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      cpu_ack_d   = 1'b0;
      ch1_valid_d = 1'b0;
      ch2_valid_d = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      ch_rdata_d  = ch_rdata_q;

      if (!cpu_req) begin
         vid_run_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (cpu_slot || (cpu_live && !ch1_live && !ch2_live)) begin
               winner_d    = REQ_CPU;
               ram_addr_d  = cpu_to_ram_addr(cpu_addr);
               ram_we_d    = cpu_write;
               ram_be_d    = {cpu_uds, cpu_lds};
               ram_wdata_d = cpu_wdata;
               // No byte lanes selected: run the handshake without touching RAM.
               nop_d       = !(cpu_uds || cpu_lds);
               ram_en_d    = cpu_uds || cpu_lds;
               vid_run_d   = '0;
               state_d     = ST_ISSUE;
            end else if (ch1_live || ch2_live) begin
               winner_d   = ch1_live ? REQ_CH1 : REQ_CH2;
               ram_addr_d = ch1_live ? ch1_addr : ch2_addr;
               ram_we_d   = 1'b0;
               ram_be_d   = 2'b11;
               nop_d      = 1'b0;
               ram_en_d   = 1'b1;
               if (cpu_req && vid_run_q != 4'hF) begin
                  vid_run_d = vid_run_q + 4'd1;
               end
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = LAT_LOAD;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q <= 3'd1) begin
               if (winner_q == REQ_CPU) begin
                  if (!ram_we_q && !nop_q) begin
                     cpu_rdata_d = ram_rdata;
                  end
                  cpu_ack_d = 1'b1;
               end else begin
                  ch_rdata_d  = ram_rdata;
                  ch1_valid_d = (winner_q == REQ_CH1);
                  ch2_valid_d = (winner_q == REQ_CH2);
               end
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         ST_RESP: begin
            mask_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         winner_q    <= REQ_CH1;
         cnt_q       <= '0;
         vid_run_q   <= '0;
         mask_q      <= 1'b0;
         nop_q       <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_be_q    <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         ch1_valid_q <= 1'b0;
         ch2_valid_q <= 1'b0;
         cpu_rdata_q <= '0;
         ch_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         winner_q    <= winner_d;
         cnt_q       <= cnt_d;
         vid_run_q   <= vid_run_d;
         mask_q      <= mask_d;
         nop_q       <= nop_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_be_q    <= ram_be_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         ch1_valid_q <= ch1_valid_d;
         ch2_valid_q <= ch2_valid_d;
         cpu_rdata_q <= cpu_rdata_d;
         ch_rdata_q  <= ch_rdata_d;
      end
   end

   assign cpu_ack   = cpu_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign ch1_valid = ch1_valid_q;
   assign ch2_valid = ch2_valid_q;
   assign ch_rdata  = ch_rdata_q;
   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_be    = ram_be_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mcd212_ram_arbiter.sv
// Scoreboard bench for mcd212_ram_arbiter: a RAM model answers accesses and
// expected RAM strobes and response pulses are queued as stimulus is driven.
module tb_mcd212_ram_arbiter;
   import mcd212_pkg::*;

   localparam int LAT  = 1;
   localparam int SLOT = 4;
   localparam int PER  = LAT + 3;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cpu_req = 1'b0;
   logic [22:1] cpu_addr = '0;
   logic        cpu_write = 1'b0;
   logic        cpu_uds = 1'b0;
   logic        cpu_lds = 1'b0;
   logic [15:0] cpu_wdata = '0;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        ch1_req = 1'b0;
   logic [18:0] ch1_addr = '0;
   logic        ch2_req = 1'b0;
   logic [18:0] ch2_addr = '0;
   logic        ch1_valid, ch2_valid;
   logic [15:0] ch_rdata;
   logic        ram_en, ram_we;
   logic [1:0]  ram_be;
   logic [18:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;

   mcd212_ram_arbiter #(.RAM_LATENCY(LAT), .CPU_SLOT_EVERY(SLOT)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_write(cpu_write),
      .cpu_uds(cpu_uds), .cpu_lds(cpu_lds), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ch1_req(ch1_req), .ch1_addr(ch1_addr), .ch2_req(ch2_req), .ch2_addr(ch2_addr),
      .ch1_valid(ch1_valid), .ch2_valid(ch2_valid), .ch_rdata(ch_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- RAM model ----------------
   logic [15:0] mem [int];
   logic [15:0] rd_pipe [LAT];
   logic [15:0] wr_word;

   function automatic logic [15:0] mem_rd(input int a);
      if (mem.exists(a)) return mem[a];
      return 16'(a) ^ 16'h3C3C;
   endfunction

   always @(posedge clk) begin
      if (ram_en && ram_we) begin
         wr_word = mem_rd(int'(ram_addr));
         if (ram_be[1]) wr_word[15:8] = ram_wdata[15:8];
         if (ram_be[0]) wr_word[7:0]  = ram_wdata[7:0];
         mem[int'(ram_addr)] = wr_word;
      end
      rd_pipe[0] <= (ram_en && !ram_we) ? mem_rd(int'(ram_addr)) : 16'hBAD0;
      for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[LAT-1];

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [1:0]  src;    // 0 = ch1, 1 = ch2, 2 = cpu
      logic [15:0] data;
   } resp_t;
   typedef struct packed {
      logic [18:0] addr;
      logic        we;
      logic [1:0]  be;
      logic [15:0] wdata;
   } acc_t;

   resp_t resp_q[$];
   acc_t  acc_q[$];
   int n_cmp = 0, n_err = 0;
   int n_en = 0, n_pulse = 0, exp_en = 0, exp_pulse = 0;
   logic [15:0] last_cpu_rd = '0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [18:0] swz(input logic [22:1] a);
      logic [18:0] r;
      r       = 19'(a[17:1]);
      r[17]   = a[21];
      r[18]   = a[18];
      return r;
   endfunction

   task automatic push_resp(input logic [1:0] src, input logic [15:0] data);
      resp_t r;
      r.src = src; r.data = data;
      resp_q.push_back(r);
      exp_pulse++;
   endtask

   task automatic push_acc(input logic [18:0] addr, input logic we, input logic [1:0] be,
                           input logic [15:0] wd);
      acc_t a;
      a.addr = addr; a.we = we; a.be = be; a.wdata = wd;
      acc_q.push_back(a);
      exp_en++;
   endtask

   resp_t r_mon;
   acc_t  a_mon;
   logic [1:0] src_mon;
   int npul;

   always @(negedge clk) begin
      if (reset_n) begin
         if (ram_en) begin
            n_en++;
            if (acc_q.size() == 0) begin
               check_val("ram_en_unexpected", 32'(ram_en), 32'd0);
            end else begin
               a_mon = acc_q.pop_front();
               $display("txn ram  addr=%05h we=%0d be=%b wdata=%04h", ram_addr, ram_we, ram_be, ram_wdata);
               check_val("ram_addr", 32'(ram_addr), 32'(a_mon.addr));
               check_val("ram_we", 32'(ram_we), 32'(a_mon.we));
               check_val("ram_be", 32'(ram_be), 32'(a_mon.be));
               if (a_mon.we) check_val("ram_wdata", 32'(ram_wdata), 32'(a_mon.wdata));
            end
         end
         npul = int'(cpu_ack) + int'(ch1_valid) + int'(ch2_valid);
         if (npul > 1) check_val("pulse_overlap", 32'(npul), 32'd1);
         if (npul != 0) begin
            n_pulse++;
            src_mon = ch1_valid ? 2'd0 : (ch2_valid ? 2'd1 : 2'd2);
            $display("txn resp src=%0d cpu_rdata=%04h ch_rdata=%04h", src_mon, cpu_rdata, ch_rdata);
            if (resp_q.size() == 0) begin
               check_val("pulse_unexpected", 32'(src_mon), 32'hFF);
            end else begin
               r_mon = resp_q.pop_front();
               check_val("resp_src", 32'(src_mon), 32'(r_mon.src));
               if (src_mon == 2'd2) check_val("cpu_rdata", 32'(cpu_rdata), 32'(r_mon.data));
               else                 check_val("ch_rdata", 32'(ch_rdata), 32'(r_mon.data));
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic drain(input string tag);
      int k = 0;
      while ((resp_q.size() != 0 || acc_q.size() != 0) && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100) check_val({tag, "_drain_timeout"}, 32'(resp_q.size() + acc_q.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
      check_val({tag, "_ch1_valid"}, 32'(ch1_valid), 32'd0);
      check_val({tag, "_ch2_valid"}, 32'(ch2_valid), 32'd0);
      check_val({tag, "_ram_en"}, 32'(ram_en), 32'd0);
      check_val({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      check_val({tag, "_ram_be"}, 32'(ram_be), 32'd0);
      check_val({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      check_val({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
      check_val({tag, "_cpu_rdata"}, 32'(cpu_rdata), 32'd0);
      check_val({tag, "_ch_rdata"}, 32'(ch_rdata), 32'd0);
   endtask

   // Isolated CPU access; expectations are queued before the request is raised.
   task automatic cpu_txn(input logic [22:1] addr, input logic we, input logic uds, input logic lds,
                          input logic [15:0] wd, input bit chk_lat, input bit late_drop);
      logic [15:0] exp;
      int t0;
      bit got;
      if (we || !(uds || lds)) begin
         exp = last_cpu_rd;
      end else begin
         exp = mem_rd(int'(swz(addr)));
         last_cpu_rd = exp;
      end
      push_resp(2'd2, exp);
      if (uds || lds) push_acc(swz(addr), we, {uds, lds}, wd);
      cpu_addr = addr; cpu_write = we; cpu_uds = uds; cpu_lds = lds; cpu_wdata = wd;
      cpu_req = 1'b1;
      t0 = cyc;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (chk_lat && ram_en) check_val("cpu_en_latency", 32'(cyc - t0), 32'd1);
         if (cpu_ack) got = 1'b1;
      end
      if (!got) check_val("cpu_ack_timeout", 32'd0, 32'd1);
      else if (chk_lat) check_val("cpu_ack_latency", 32'(cyc - t0), 32'(2 + LAT));
      if (late_drop) repeat (2) @(negedge clk);
      cpu_req = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int t0, np, ncpu, last_cpu, pulses_before;
   int tp [3];
   logic [1:0] seq4 [10];

   initial begin
      mem[32'h80]    = 16'h5AA5;
      mem[32'h40000] = 16'hABCD;
      mem[32'h100]   = 16'h7E81;

      // Reset state
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single CPU read, byte address 0x000100
      cpu_txn(22'h80, 1'b0, 1'b1, 1'b1, 16'h0, 1'b1, 1'b0);
      drain("t1");

      // 2: CPU upper-byte write to bank 1 (A18)
      cpu_txn(22'h20000, 1'b1, 1'b1, 1'b0, 16'h12FF, 1'b1, 1'b0);
      drain("t2");
      check_val("t2_mem_word", 32'(mem_rd(32'h40000)), 32'h12CD);
      check_val("t2_rdata_kept", 32'(cpu_rdata), 32'h5AA5);

      // 3: simultaneous ch1, ch2, cpu
      ch1_addr = 19'h01111; ch2_addr = 19'h02222;
      cpu_addr = 22'h300; cpu_write = 1'b0; cpu_uds = 1'b1; cpu_lds = 1'b1;
      push_resp(2'd0, mem_rd(32'h01111)); push_acc(19'h01111, 1'b0, 2'b11, 16'h0);
      push_resp(2'd1, mem_rd(32'h02222)); push_acc(19'h02222, 1'b0, 2'b11, 16'h0);
      last_cpu_rd = mem_rd(32'h300);
      push_resp(2'd2, last_cpu_rd);       push_acc(19'h00300, 1'b0, 2'b11, 16'h0);
      ch1_req = 1'b1; ch2_req = 1'b1; cpu_req = 1'b1;
      t0 = cyc; np = 0;
      for (int k = 0; k < 60 && np < 3; k++) begin
         @(negedge clk);
         if (ch1_valid) begin ch1_req = 1'b0; tp[np] = cyc; np++; end
         if (ch2_valid) begin ch2_req = 1'b0; tp[np] = cyc; np++; end
         if (cpu_ack)   begin cpu_req = 1'b0; tp[np] = cyc; np++; end
      end
      ch1_req = 1'b0; ch2_req = 1'b0; cpu_req = 1'b0;
      check_val("t3_pulse_count", 32'(np), 32'd3);
      if (np == 3) begin
         check_val("t3_first_latency", 32'(tp[0] - t0), 32'(2 + LAT));
         check_val("t3_gap_1", 32'(tp[1] - tp[0]), 32'(PER));
         check_val("t3_gap_2", 32'(tp[2] - tp[1]), 32'(PER));
      end
      drain("t3");

      // 4: ch1, ch2 and cpu all requesting continuously -> starvation slot after 4 video grants
      seq4 = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
      ch1_addr = 19'h05000; ch2_addr = 19'h06000; cpu_addr = 22'h500;
      cpu_write = 1'b0; cpu_uds = 1'b1; cpu_lds = 1'b1;
      for (int i = 0; i < 10; i++) begin
         case (seq4[i])
            2'd0: begin push_resp(2'd0, mem_rd(32'h05000)); push_acc(19'h05000, 1'b0, 2'b11, 16'h0); end
            2'd1: begin push_resp(2'd1, mem_rd(32'h06000)); push_acc(19'h06000, 1'b0, 2'b11, 16'h0); end
            default: begin push_resp(2'd2, mem_rd(32'h500)); push_acc(19'h00500, 1'b0, 2'b11, 16'h0); end
         endcase
      end
      last_cpu_rd = mem_rd(32'h500);
      ch1_req = 1'b1; ch2_req = 1'b1; cpu_req = 1'b1;
      last_cpu = cyc; np = 0; ncpu = 0;
      for (int k = 0; k < 150 && np < 10; k++) begin
         @(negedge clk);
         if (cpu_ack || ch1_valid || ch2_valid) np++;
         if (cpu_ack) begin
            check_val("t4_cpu_wait_bounded", 32'((cyc - last_cpu) <= (SLOT * PER + PER)), 32'd1);
            last_cpu = cyc;
            ncpu++;
         end
      end
      ch1_req = 1'b0; ch2_req = 1'b0; cpu_req = 1'b0;
      check_val("t4_pulse_count", 32'(np), 32'd10);
      check_val("t4_cpu_grants", 32'(ncpu), 32'd2);
      drain("t4");

      // 5: requesters hold req one cycle past their pulse
      cpu_txn(22'h100, 1'b0, 1'b1, 1'b1, 16'h0, 1'b1, 1'b1);
      drain("t5a");
      ch1_addr = 19'h00100;
      push_resp(2'd0, mem_rd(32'h100)); push_acc(19'h00100, 1'b0, 2'b11, 16'h0);
      ch1_req = 1'b1;
      np = 0;
      for (int k = 0; k < 40 && np == 0; k++) begin
         @(negedge clk);
         if (ch1_valid) np = 1;
      end
      check_val("t5_ch1_seen", 32'(np), 32'd1);
      repeat (2) @(negedge clk);
      ch1_req = 1'b0;
      drain("t5b");
      check_val("t5_en_count", 32'(n_en), 32'(exp_en));
      check_val("t5_pulse_count", 32'(n_pulse), 32'(exp_pulse));

      // CPU access with no byte lanes: acked, no RAM strobe, read data untouched
      cpu_txn(22'h700, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
      drain("tz");
      check_val("tz_en_count", 32'(n_en), 32'(exp_en));

      // 6: reset during WAIT of a ch2 read
      ch2_addr = 19'h01234;
      push_acc(19'h01234, 1'b0, 2'b11, 16'h0);
      ch2_req = 1'b1;
      pulses_before = n_pulse;
      @(negedge clk);
      check_val("t6_ram_en", 32'(ram_en), 32'd1);
      ch2_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_all_zero("t6_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      check_val("t6_no_valid", 32'(n_pulse), 32'(pulses_before));
      last_cpu_rd = 16'h0;
      cpu_txn(22'h80, 1'b0, 1'b1, 1'b1, 16'h0, 1'b1, 1'b0);
      drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

endmodule
